// File: rtl/alu4_seq_ctrl.sv
// alu4_seq_ctrl
//   Multi-nibble sequencer wrapped around a 4-bit alu4 slice. Takes one
//   command per handshake and feeds the ALU one nibble per cycle, LSB first.
//   Carry is chained between nibbles. The result is collected into an
//   accumulator that has carry and zero flags.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADC, 7 CLR
//   cmd_operand           right-hand (b side) operand, W bits
//   alu_x/y/z/w, alu_ci   alu4 operation select and carry in
//   alu_a, alu_b          current accumulator / operand nibble
//   alu_c, alu_g          alu4 carry vector (bit 3 used) and result nibble
//   acc, flag_c, flag_z   accumulator and flags
//   done                  one-cycle pulse when a command retires

module alu4_seq_ctrl #(
    parameter int unsigned WORD_NIBBLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [4*WORD_NIBBLES-1:0] cmd_operand,
    output logic                      alu_x,
    output logic                      alu_y,
    output logic                      alu_z,
    output logic                      alu_w,
    output logic                      alu_ci,
    output logic [3:0]                alu_a,
    output logic [3:0]                alu_b,
    input  logic [3:0]                alu_c,
    input  logic [3:0]                alu_g,
    output logic [4*WORD_NIBBLES-1:0] acc,
    output logic                      flag_c,
    output logic                      flag_z,
    output logic                      done
);

    localparam int unsigned W     = 4 * WORD_NIBBLES;
    localparam int unsigned NIB_W = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(WORD_NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PASS,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_ADC  = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    state_e           state_q,   state_d;
    op_e              op_q,      op_d;
    logic [W-1:0]     operand_q, operand_d;
    logic [W-1:0]     acc_q,     acc_d;
    logic [W-1:0]     shadow_q,  shadow_d;
    logic [NIB_W-1:0] nib_q,     nib_d;
    logic             carry_q,   carry_d;
    logic             flag_c_q,  flag_c_d;
    logic             flag_z_q,  flag_z_d;

    logic [3:0] sel;
    logic       is_arith;

    // Only the top carry bit of the slice is meaningful to the sequencer.
    logic unused_alu_c;
    assign unused_alu_c = ^alu_c[2:0];

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);

    assign {alu_x, alu_y, alu_z, alu_w} = sel;
    assign acc    = acc_q;
    assign flag_c = flag_c_q;
    assign flag_z = flag_z_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            operand_q <= '0;
            acc_q     <= '0;
            shadow_q  <= '0;
            nib_q     <= '0;
            carry_q   <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            shadow_q  <= shadow_d;
            nib_q     <= nib_d;
            carry_q   <= carry_d;
            flag_c_q  <= flag_c_d;
            flag_z_q  <= flag_z_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        shadow_d  = shadow_q;
        nib_d     = nib_q;
        carry_d   = carry_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        sel       = 4'b0000;
        alu_ci    = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d      = op_e'(cmd_op);
                    operand_d = cmd_operand;
                    case (op_e'(cmd_op))
                        OP_LOAD: begin
                            acc_d    = cmd_operand;
                            flag_c_d = 1'b0;
                            flag_z_d = (cmd_operand == '0);
                            state_d  = S_DONE;
                        end
                        OP_CLR: begin
                            acc_d    = '0;
                            flag_c_d = 1'b0;
                            flag_z_d = 1'b1;
                            state_d  = S_DONE;
                        end
                        default: begin
                            nib_d   = '0;
                            state_d = S_PASS;
                        end
                    endcase
                end
            end

            S_PASS: begin
                alu_a = acc_q[{nib_q, 2'b00} +: 4];
                alu_b = operand_q[{nib_q, 2'b00} +: 4];

                case (op_q)
                    OP_ADD, OP_ADC: sel = 4'b0100;
                    OP_SUB:         sel = 4'b1100;
                    OP_AND:         sel = 4'b0010;
                    OP_OR:          sel = 4'b0011;
                    default:        sel = 4'b0000;
                endcase

                // Nibble 0 seeds the chain: SUB needs +1 for two's complement,
                // ADC takes the retained carry flag; later nibbles take the ripple.
                if (nib_q == '0) begin
                    case (op_q)
                        OP_SUB:  alu_ci = 1'b1;
                        OP_ADC:  alu_ci = flag_c_q;
                        default: alu_ci = 1'b0;
                    endcase
                end else begin
                    alu_ci = is_arith & carry_q;
                end

                shadow_d[{nib_q, 2'b00} +: 4] = alu_g;
                carry_d = alu_c[3];
                nib_d   = nib_q + 1'b1;

                if (nib_q == LAST_NIB) begin
                    acc_d    = shadow_d;
                    flag_c_d = is_arith & alu_c[3];
                    flag_z_d = (shadow_d == '0);
                    nib_d    = '0;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
module tb_alu4_seq_ctrl;

    localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                           OR_ = 3'd4, XOR_ = 3'd5, ADC = 3'd6, CLR = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       alu_x, alu_y, alu_z, alu_w, alu_ci;
    logic [3:0] alu_a, alu_b, alu_c, alu_g;
    logic [7:0] acc;
    logic       flag_c, flag_z, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu4_seq_ctrl #(.WORD_NIBBLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_z       (alu_z),
        .alu_w       (alu_w),
        .alu_ci      (alu_ci),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_g       (alu_g),
        .acc         (acc),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .done        (done)
    );

    // Behavioural alu4 slice sitting behind the ports.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = 5'd0;
        alu_g   = 4'h0;
        alu_c   = 4'h0;
        case ({alu_x, alu_y, alu_z, alu_w})
            4'b0100: begin
                alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci};
                alu_g   = alu_sum[3:0];
                alu_c   = {alu_sum[4], 3'b000};
            end
            4'b1100: begin
                alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_ci};
                alu_g   = alu_sum[3:0];
                alu_c   = {alu_sum[4], 3'b000};
            end
            4'b0010: alu_g = alu_a & alu_b;
            4'b0011: alu_g = alu_a | alu_b;
            default: alu_g = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $error("FAIL %s_ready_timeout: observed cmd_ready=%b expected 1", tag, cmd_ready);
        end
    endtask

    // Issue one command, wait (bounded) for done, check latency and results.
    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] opd,
                       input int exp_lat, input logic [7:0] exp_acc,
                       input logic exp_c, input logic exp_z);
        int lat;
        wait_ready(tag);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opd;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_operand = 8'($urandom);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
        end
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        check({tag, "_acc"}, {8'h00, acc}, {8'h00, exp_acc});
        check({tag, "_c"}, {15'd0, flag_c}, {15'd0, exp_c});
        check({tag, "_z"}, {15'd0, flag_z}, {15'd0, exp_z});
        @(negedge clk);
        check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_operand = 8'h00;
        #2;
        check("rst_acc",   {8'h00, acc}, 16'h0000);
        check("rst_flags", {14'd0, flag_c, flag_z}, 16'h0001);
        check("rst_done",  {15'd0, done}, 16'd0);
        check("rst_ready", {15'd0, cmd_ready}, 16'd1);
        check("rst_alu",   {5'd0, alu_x, alu_y, alu_z, alu_w, alu_ci, alu_a, alu_b}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1. LOAD then ADD with carry out of the top nibble
        run("t1_load", LOAD, 8'h3C, 1, 8'h3C, 1'b0, 1'b0);
        run("t1_add",  ADD,  8'hC8, 3, 8'h04, 1'b1, 1'b0);

        // 2. SUB with borrow, then SUB to zero without borrow
        run("t2_load", LOAD, 8'h50, 1, 8'h50, 1'b0, 1'b0);
        run("t2_sub1", SUB,  8'h51, 3, 8'hFF, 1'b0, 1'b0);
        run("t2_sub2", SUB,  8'hFF, 3, 8'h00, 1'b1, 1'b1);

        // 3. ADC consumes the carry left by the previous ADD
        run("t3_load", LOAD, 8'hFF, 1, 8'hFF, 1'b0, 1'b0);
        run("t3_add",  ADD,  8'h01, 3, 8'h00, 1'b1, 1'b1);
        run("t3_adc",  ADC,  8'h10, 3, 8'h11, 1'b0, 1'b0);

        // CLR after a carry-setting op
        run("t3_add2", ADD,  8'hF0, 3, 8'h01, 1'b1, 1'b0);
        run("t3_clr",  CLR,  8'h77, 1, 8'h00, 1'b0, 1'b1);

        // 4. logic ops
        run("t4_load", LOAD, 8'hCA, 1, 8'hCA, 1'b0, 1'b0);
        run("t4_and",  AND_, 8'hAC, 3, 8'h88, 1'b0, 1'b0);
        run("t4_or",   OR_,  8'h03, 3, 8'h8B, 1'b0, 1'b0);
        run("t4_xor",  XOR_, 8'h8B, 3, 8'h00, 1'b0, 1'b1);

        // 5. cmd_valid held with changing command while busy
        run("t5_load", LOAD, 8'h10, 1, 8'h10, 1'b0, 1'b0);
        wait_ready("t5_add");
        cmd_valid   = 1'b1;
        cmd_op      = ADD;
        cmd_operand = 8'h01;
        @(posedge clk);
        #1;
        cmd_op      = OR_;
        cmd_operand = 8'h20;
        @(negedge clk);
        check("t5_ready_c1", {15'd0, cmd_ready}, 16'd0);
        cmd_operand = 8'h40;
        @(negedge clk);
        check("t5_ready_c2", {15'd0, cmd_ready}, 16'd0);
        cmd_operand = 8'h80;
        @(negedge clk);
        check("t5_ready_c3", {15'd0, cmd_ready}, 16'd0);
        check("t5_done",     {15'd0, done}, 16'd1);
        check("t5_acc",      {8'h00, acc}, 16'h0011);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t5_ready_back", {15'd0, cmd_ready}, 16'd1);
        check("t5_acc_hold",   {8'h00, acc}, 16'h0011);
        check("t5_no_done",    {15'd0, done}, 16'd0);

        // 6. reset during PASS nib=1
        run("t6_load", LOAD, 8'h12, 1, 8'h12, 1'b0, 1'b0);
        wait_ready("t6_add");
        cmd_valid   = 1'b1;
        cmd_op      = ADD;
        cmd_operand = 8'h11;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t6_nib0_a", {12'd0, alu_a}, 16'h0002);
        @(negedge clk);
        check("t6_nib1_a", {12'd0, alu_a}, 16'h0001);
        reset = 1'b1;
        #1;
        check("t6_rst_acc",   {8'h00, acc}, 16'h0000);
        check("t6_rst_flags", {14'd0, flag_c, flag_z}, 16'h0001);
        check("t6_rst_done",  {15'd0, done}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_post_done",  {15'd0, done}, 16'd0);
            check("t6_post_ready", {15'd0, cmd_ready}, 16'd1);
            check("t6_post_acc",   {8'h00, acc}, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
